// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings as presented by ID/EX (op_i)
//   - sequencer state encoding (exported on state_o for debug)
//   - default operand width and the matching step-counter width
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mdu_state_e;

    // bit 1 of the op selects divide, bit 0 selects the unsigned variant
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: pipeline-side bundle of the multiply/divide unit.
//   master (pipeline/testbench) drives: start_i, op_i, src1_i, src2_i,
//     mfhilo_i, mthi_i, mtlo_i
//   slave (mdu_iterative) drives: hi_o, lo_o, busy_o, done_o, stall_o,
//     state_o (sequencer state, debug visibility)
// Handshake: an instruction is presented on start_i/mfhilo_i/mthi_i/mtlo_i
// with its operands and is consumed at the rising clk edge where the unit can
// take it; while stall_o is high the pipeline must hold and re-present the
// same instruction unchanged on the following cycle.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             mfhilo_i;
    logic             mthi_i;
    logic             mtlo_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;
    mdu_state_e       state_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, mfhilo_i, mthi_i, mtlo_i,
        input  hi_o, lo_o, busy_o, done_o, stall_o, state_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, mfhilo_i, mthi_i, mtlo_i,
        output hi_o, lo_o, busy_o, done_o, stall_o, state_o
    );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the unsigned multiply/divide core.
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : multiply -> {partial product, remaining multiplier bits}
//              divide   -> {partial remainder, dividend/quotient bits}
//   opnd     : multiplicand (multiply) or divisor (divide), magnitudes
//   acc_next : accumulator after this step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;

    always_comb begin
        acc_next = acc;
        // Multiply: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole register right; the
        // carry lands in the top bit.
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: shift the next dividend bit into the remainder and try
        // subtracting the divisor. The remainder is always below the divisor,
        // so the shifted value fits WIDTH+1 bits and bit WIDTH is the borrow.
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO (EX stage).
//   clk_i : pipeline clock
//   rst_i : asynchronous active-high reset, discards any operation
//   bus   : mdu_if.slave - operands/controls in, HI/LO, busy/done/stall and
//           sequencer state out
// An operation accepted in IDLE runs WIDTH steps in RUN on operand
// magnitudes, writes sign-corrected results to HI/LO on the last step and
// spends one cycle in DONE (done_o) before returning to IDLE.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic  clk_i,
    input logic  rst_i,
    mdu_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_next;
    logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
    logic               div_q, neg_q_q, neg_r_q;

    logic               accept, last_step;
    logic               dz, s1_neg, s2_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    assign accept    = (state_q == S_IDLE) & bus.start_i;
    assign last_step = (state_q == S_RUN) & (cnt_q == LAST);

    // Operand preparation. A divide by zero runs on the raw dividend with no
    // sign correction: the restoring core then yields quotient = all ones and
    // remainder = dividend, which is exactly the required result for both
    // DIV and DIVU.
    always_comb begin
        dz     = op_is_div(bus.op_i) & (bus.src2_i == '0);
        s1_neg = op_is_signed(bus.op_i) & bus.src1_i[WIDTH-1] & ~dz;
        s2_neg = op_is_signed(bus.op_i) & bus.src2_i[WIDTH-1];
        mag1   = s1_neg ? -bus.src1_i : bus.src1_i;
        mag2   = s2_neg ? -bus.src2_i : bus.src2_i;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    // Sign correction of the final step's output (modulo 2^WIDTH per half)
    always_comb begin
        prod = neg_q_q ? -acc_next : acc_next;
        quo  = neg_q_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem  = neg_r_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
        if (div_q) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                div_q   <= op_is_div(bus.op_i);
                neg_q_q <= s1_neg ^ s2_neg;
                neg_r_q <= s1_neg;
                if (op_is_div(bus.op_i)) begin
                    acc_q  <= {{WIDTH{1'b0}}, mag1};
                    opnd_q <= mag2;
                end else begin
                    acc_q  <= {{WIDTH{1'b0}}, mag2};
                    opnd_q <= mag1;
                end
            end else if (state_q == S_RUN) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + 1'b1;
            end

            // MT writes land in IDLE or DONE only; a write in the DONE cycle
            // happens one edge after the result write and so overrides it.
            if (last_step) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q != S_RUN) begin
                if (bus.mthi_i) hi_q <= bus.src1_i;
                if (bus.mtlo_i) lo_q <= bus.src1_i;
            end
        end
    end

    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.stall_o = (state_q == S_RUN) &
                         (bus.start_i | bus.mfhilo_i | bus.mthi_i | bus.mtlo_i);
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: self-checking bench for mdu_iterative. Results are
// predicted with plain 64-bit arithmetic on the architectural definition of
// each op and queued in exp_q; HI/LO expectations between operations come
// from model_hi/model_lo.
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_iterative #(.WIDTH(W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0]   model_hi = '0;
    logic [W-1:0]   model_lo = '0;
    logic [2*W-1:0] exp_q[$];

    // Reference: {HI, LO} for one operation
    function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub, up;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            OP_MULT: begin
                p   = sa * sb;
                res = p;
            end
            OP_MULTU: begin
                up  = ua * ub;
                res = up;
            end
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Present an op in IDLE; it is accepted at the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        exp_q.push_back(ref_mdu(op, a, b));
    endtask

    // Follow an accepted op to completion; 'already' = busy cycles consumed
    // by the caller since the accepting edge.
    task automatic wait_result(input string name, input int already);
        int busy_cnt;
        int done_at;
        logic stable_bad;
        logic [63:0] exp;
        busy_cnt   = already;
        done_at    = 0;
        stable_bad = 1'b0;
        exp        = exp_q.pop_front();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
            busy_cnt++;
            if (bus.done_o) begin
                done_at = busy_cnt;
                checks++;
                if ({bus.hi_o, bus.lo_o} !== exp) begin
                    failures++;
                    $display("FAIL %s result hi_lo=%h expected=%h", name, {bus.hi_o, bus.lo_o}, exp);
                end
            end else if ({bus.hi_o, bus.lo_o} !== {model_hi, model_lo}) begin
                stable_bad = 1'b1;
            end
        end
        checks++;
        if (busy_cnt != 33) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d expected=33", name, busy_cnt);
        end
        checks++;
        if (done_at != 33) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d expected=33", name, done_at);
        end
        checks++;
        if (stable_bad) begin
            failures++;
            $display("FAIL %s hilo_changed_during_run got=1 expected=0", name);
        end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.hi_o, bus.lo_o} !== 64'd0) begin
            failures++;
            $display("FAIL reset_hilo got=%h expected=0", {bus.hi_o, bus.lo_o});
        end
        checks++;
        if ({bus.busy_o, bus.done_o, bus.stall_o} !== 3'b000 || bus.state_o !== S_IDLE) begin
            failures++;
            $display("FAIL reset_ctrl busy_done_stall=%b state=%0d expected=000/0",
                     {bus.busy_o, bus.done_o, bus.stall_o}, bus.state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_result("multu_fffffffe_x3", 0);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_result("mult_neg2_x3", 0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_m7_by_2", 0);
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_result("divu_by_zero", 0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_min_by_m1", 0);
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd0);
        wait_result("div_neg_by_zero", 0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            issue(op, a, b);
            wait_result($sformatf("random_%0d_op%0d", i, op), 0);
        end
    endtask

    task automatic test_hazards();
        int cyc;
        int done_at;
        logic idle_seen;
        logic [63:0] exp;
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        exp       = exp_q.pop_front();
        cyc       = 0;
        done_at   = 0;
        idle_seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (!bus.busy_o) begin
                idle_seen = 1'b1;
                break;
            end
            cyc++;
            bus.mfhilo_i = (cyc == 5);
            if (cyc == 5) begin
                #1;
                checks++;
                if (bus.stall_o !== 1'b1) begin
                    failures++;
                    $display("FAIL mfhilo_stall got=%b expected=1", bus.stall_o);
                end
                checks++;
                if ({bus.hi_o, bus.lo_o} !== {model_hi, model_lo}) begin
                    failures++;
                    $display("FAIL mfhilo_hilo got=%h expected=%h", {bus.hi_o, bus.lo_o},
                             {model_hi, model_lo});
                end
            end
            if (cyc == 8) begin
                bus.start_i = 1'b1;
                bus.op_i    = OP_DIVU;
                bus.src1_i  = 32'd100;
                bus.src2_i  = 32'd7;
                #1;
                checks++;
                if (bus.stall_o !== 1'b1) begin
                    failures++;
                    $display("FAIL second_start_stall got=%b expected=1", bus.stall_o);
                end
            end
            if (bus.done_o) begin
                done_at = cyc;
                checks++;
                if ({bus.hi_o, bus.lo_o} !== exp) begin
                    failures++;
                    $display("FAIL first_result_uncorrupted got=%h expected=%h",
                             {bus.hi_o, bus.lo_o}, exp);
                end
                checks++;
                if (bus.stall_o !== 1'b0) begin
                    failures++;
                    $display("FAIL done_stall got=%b expected=0", bus.stall_o);
                end
            end
        end
        checks++;
        if (done_at != 33 || !idle_seen) begin
            failures++;
            $display("FAIL first_op_timing done_at=%0d idle_seen=%b expected=33/1", done_at, idle_seen);
        end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        // start_i still held: accepted now that the unit is back in IDLE
        exp_q.push_back(ref_mdu(OP_DIVU, 32'd100, 32'd7));
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        wait_result("second_start_after_idle", 0);
    endtask

    task automatic test_mt();
        logic [63:0] exp;
        logic seen;
        // MTLO in IDLE
        @(negedge clk);
        bus.mtlo_i = 1'b1;
        bus.src1_i = 32'h0000_1234;
        @(posedge clk);
        #1 bus.mtlo_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.hi_o, bus.lo_o} !== {model_hi, 32'h0000_1234}) begin
            failures++;
            $display("FAIL mtlo_idle got=%h expected=%h", {bus.hi_o, bus.lo_o}, {model_hi, 32'h0000_1234});
        end
        model_lo = 32'h0000_1234;

        // MTLO during RUN is ignored and stalls
        issue(OP_MULTU, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        bus.mtlo_i = 1'b1;
        bus.src1_i = 32'h0000_DEAD;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            failures++;
            $display("FAIL mtlo_run_stall got=%b expected=1", bus.stall_o);
        end
        @(posedge clk);
        #1 bus.mtlo_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.lo_o !== model_lo) begin
            failures++;
            $display("FAIL mtlo_run_ignored got=%h expected=%h", bus.lo_o, model_lo);
        end
        wait_result("mult_after_run_mtlo", 3);

        // MTHI in the DONE cycle overrides HI of the result
        issue(OP_MULTU, 32'h10, 32'h10);
        exp  = exp_q.pop_front();
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done_o) begin
                seen        = 1'b1;
                bus.mthi_i  = 1'b1;
                bus.src1_i  = 32'hCAFE_F00D;
                @(posedge clk);
                #1 bus.mthi_i = 1'b0;
                @(negedge clk);
                break;
            end
        end
        checks++;
        if (!seen || {bus.hi_o, bus.lo_o} !== {32'hCAFE_F00D, exp[31:0]}) begin
            failures++;
            $display("FAIL mthi_done_override seen=%b got=%h expected=%h", seen,
                     {bus.hi_o, bus.lo_o}, {32'hCAFE_F00D, exp[31:0]});
        end
        model_hi = 32'hCAFE_F00D;
        model_lo = exp[31:0];
    endtask

    task automatic test_async_reset();
        issue(OP_MULTU, 32'h1234_5678, 32'd9);
        void'(exp_q.pop_front());
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.stall_o} !== 3'b000 || bus.state_o !== S_IDLE) begin
            failures++;
            $display("FAIL async_reset_ctrl busy_done_stall=%b state=%0d expected=000/0",
                     {bus.busy_o, bus.done_o, bus.stall_o}, bus.state_o);
        end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== 64'd0) begin
            failures++;
            $display("FAIL async_reset_hilo got=%h expected=0", {bus.hi_o, bus.lo_o});
        end
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(OP_MULTU, 32'd5, 32'd7);
        wait_result("multu_5x7_after_reset", 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.op_i     = OP_MULT;
        bus.src1_i   = '0;
        bus.src2_i   = '0;
        bus.mfhilo_i = 1'b0;
        bus.mthi_i   = 1'b0;
        bus.mtlo_i   = 1'b0;
        test_reset();
        test_directed();
        test_hazards();
        test_mt();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
